bus_mem_io: RTL and testbench

Bus responder for the core's single-port memory bus: it answers every word-address cycle with registered read data and applies byte-masked writes. It holds the instruction/data RAM and a small MMIO page: a UART transmitter with a TX FIFO, a free-running cycle counter and a GPIO output register. It sits directly on the core's bus, with no arbitration or wait states.

---
 rtl/bus_mem_io.sv | 231 +++++++++++++++++++++++
 tb/tb_bus_mem_io.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_io.sv
// Single-port bus responder: word RAM with byte-masked writes plus an MMIO page
// holding a UART transmitter (TX FIFO), a free-running cycle counter and GPIO.
module bus_mem_io #(
  parameter int    RAM_WORDS = 4096,
  parameter string INIT_FILE = "",
  parameter int    UART_DIV  = 868,
  parameter int    TX_DEPTH  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] bus_addr,
  output logic [31:0] bus_data_r,
  input  logic [31:0] bus_data_w,
  input  logic [3:0]  bus_mask_w,
  output logic        uart_tx,
  output logic [31:0] gpio_out
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(TX_DEPTH);
  localparam int CW = FW + 1;
  localparam int DW = $clog2(UART_DIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  logic [31:0]   mem_r [RAM_WORDS];
  logic [31:0]   ram_rd_r;
  logic [31:0]   mmio_rd_r;
  logic          sel_mmio_r;
  logic [31:0]   mmio_rd_s;

  logic [31:0]   cycles_r;
  logic [31:0]   gpio_r;
  logic          ovf_r;

  logic [7:0]    fifo_mem_r [TX_DEPTH];
  logic [FW-1:0] wr_ptr_r;
  logic [FW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  tx_state_t     state_r, state_n;
  logic [DW-1:0] div_r, div_n;
  logic [2:0]    bit_r, bit_n;
  logic [7:0]    shift_r, shift_n;
  logic          tx_r, tx_n;
  logic          pop_s;

  logic          wr_s, mmio_s, push_req_s, push_s, stat_wr_s, gpio_wr_s;
  logic          full_s, empty_s, busy_s, div_end_s;
  logic          unused_s;

  assign wr_s       = |bus_mask_w;
  assign mmio_s     = bus_addr[29];
  assign push_req_s = wr_s && mmio_s && (bus_addr[1:0] == 2'd0) && bus_mask_w[0];
  assign stat_wr_s  = wr_s && mmio_s && (bus_addr[1:0] == 2'd1);
  assign gpio_wr_s  = wr_s && mmio_s && (bus_addr[1:0] == 2'd3);
  assign full_s     = (count_r == CW'(TX_DEPTH));
  assign empty_s    = (count_r == CW'(0));
  assign push_s     = push_req_s && !full_s;
  assign busy_s     = !empty_s || (state_r != ST_IDLE);
  assign div_end_s  = (div_r == DW'(UART_DIV - 1));
  assign unused_s   = ^bus_addr[28:AW];

  // MMIO read mux, sampling register state before this cycle's update
  always_comb begin
    mmio_rd_s = 32'h0000_0000;
    case (bus_addr[1:0])
      2'd0:    mmio_rd_s = 32'h0000_0000;
      2'd1:    mmio_rd_s = {29'd0, ovf_r, busy_s, full_s};
      2'd2:    mmio_rd_s = cycles_r;
      2'd3:    mmio_rd_s = gpio_r;
      default: mmio_rd_s = 32'h0000_0000;
    endcase
  end

  // Read path: no reset so RAM word 0 is already presented as reset releases
  always_ff @(posedge clock) begin
    ram_rd_r   <= mem_r[bus_addr[AW-1:0]];
    mmio_rd_r  <= mmio_rd_s;
    sel_mmio_r <= mmio_s;
  end

  assign bus_data_r = sel_mmio_r ? mmio_rd_r : ram_rd_r;

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_s && !mmio_s && bus_mask_w[i]) begin
        mem_r[bus_addr[AW-1:0]][8*i +: 8] <= bus_data_w[8*i +: 8];
      end
    end
  end

  // TX FIFO storage
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= bus_data_w[7:0];
    end
  end

  // Counter, GPIO, overflow flag and FIFO bookkeeping
  always_ff @(posedge clock) begin
    if (!reset) begin
      cycles_r <= 32'h0000_0000;
      gpio_r   <= 32'h0000_0000;
      ovf_r    <= 1'b0;
      wr_ptr_r <= FW'(0);
      rd_ptr_r <= FW'(0);
      count_r  <= CW'(0);
    end else begin
      cycles_r <= cycles_r + 32'd1;
      for (int i = 0; i < 4; i++) begin
        if (gpio_wr_s && bus_mask_w[i]) begin
          gpio_r[8*i +: 8] <= bus_data_w[8*i +: 8];
        end
      end
      // Drop decision uses the count at cycle start, so a same-cycle pop does not help
      if (push_req_s && full_s) begin
        ovf_r <= 1'b1;
      end else if (stat_wr_s) begin
        ovf_r <= 1'b0;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // UART transmitter next-state logic; a queued byte starts straight out of STOP
  always_comb begin
    state_n = state_r;
    div_n   = div_r;
    bit_n   = bit_r;
    shift_n = shift_r;
    tx_n    = tx_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_n = fifo_mem_r[rd_ptr_r];
          div_n   = DW'(0);
          bit_n   = 3'd0;
          tx_n    = 1'b0;
          state_n = ST_START;
        end else begin
          tx_n    = 1'b1;
        end
      end
      ST_START: begin
        if (div_end_s) begin
          div_n   = DW'(0);
          tx_n    = shift_r[0];
          state_n = ST_DATA;
        end else begin
          div_n   = div_r + 1'b1;
        end
      end
      ST_DATA: begin
        if (div_end_s) begin
          div_n = DW'(0);
          if (bit_r == 3'd7) begin
            tx_n    = 1'b1;
            state_n = ST_STOP;
          end else begin
            bit_n   = bit_r + 1'b1;
            shift_n = {1'b0, shift_r[7:1]};
            tx_n    = shift_r[1];
          end
        end else begin
          div_n = div_r + 1'b1;
        end
      end
      ST_STOP: begin
        if (div_end_s) begin
          div_n = DW'(0);
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_n = fifo_mem_r[rd_ptr_r];
            bit_n   = 3'd0;
            tx_n    = 1'b0;
            state_n = ST_START;
          end else begin
            tx_n    = 1'b1;
            state_n = ST_IDLE;
          end
        end else begin
          div_n = div_r + 1'b1;
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = ST_IDLE;
      end
    endcase
  end

  // UART transmitter state register; reset aborts any frame in progress
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      div_r   <= DW'(0);
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_n;
      div_r   <= div_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
      tx_r    <= tx_n;
    end
  end

  assign uart_tx  = tx_r;
  assign gpio_out = gpio_r;

endmodule

// File: tb/tb_bus_mem_io.sv
// Directed self-checking bench for bus_mem_io: boot read, byte writes, UART frame,
// FIFO overflow with back-to-back frames, CYCLES/GPIO and reset mid-frame.
module tb_bus_mem_io;

  localparam logic [29:0] A_TX   = 30'h2000_0000;
  localparam logic [29:0] A_ST   = 30'h2000_0001;
  localparam logic [29:0] A_CYC  = 30'h2000_0002;
  localparam logic [29:0] A_GPIO = 30'h2000_0003;

  logic        clock = 1'b0;
  logic        reset;
  logic [29:0] bus_addr;
  logic [31:0] bus_data_r;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;
  logic        uart_tx;
  logic [31:0] gpio_out;

  int errors = 0;
  int checks = 0;

  int   tb_cyc = 0;
  logic mon_en = 1'b0;
  logic mon_clr = 1'b0;
  logic prev_tx = 1'b1;
  int   fall_cnt = 0;
  int   first_fall = 0;
  int   last_fall = 0;

  always #5 clock = ~clock;

  bus_mem_io #(
    .RAM_WORDS(256),
    .INIT_FILE(""),
    .UART_DIV(4),
    .TX_DEPTH(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus_addr(bus_addr),
    .bus_data_r(bus_data_r),
    .bus_data_w(bus_data_w),
    .bus_mask_w(bus_mask_w),
    .uart_tx(uart_tx),
    .gpio_out(gpio_out)
  );

  // Start-bit monitor: counts falling edges of the serial line
  always @(negedge clock) begin
    tb_cyc  <= tb_cyc + 1;
    prev_tx <= uart_tx;
    if (mon_clr) begin
      fall_cnt <= 0;
    end else if (mon_en && prev_tx && !uart_tx) begin
      if (fall_cnt == 0) first_fall <= tb_cyc;
      last_fall <= tb_cyc;
      fall_cnt  <= fall_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clock);
    bus_addr   = a;
    bus_data_w = d;
    bus_mask_w = m;
  endtask

  task automatic bus_wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                        output logic [31:0] old);
    drive(a, d, m);
    @(negedge clock);
    old        = bus_data_r;
    bus_mask_w = 4'h0;
  endtask

  task automatic bus_rd(input logic [29:0] a, output logic [31:0] v);
    drive(a, 32'h0, 4'h0);
    @(negedge clock);
    v = bus_data_r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v, old, c0, c1;
    logic [9:0]  frame;
    int          lows;

    reset      = 1'b0;
    bus_addr   = 30'h0;
    bus_data_w = 32'h0;
    bus_mask_w = 4'h0;
    repeat (3) @(negedge clock);
    reset    = 1'b1;
    bus_addr = A_CYC;
    check_eq("rst_uart_tx", {31'd0, uart_tx}, 32'h1);
    check_eq("rst_gpio_out", gpio_out, 32'h0);
    @(negedge clock);
    check_eq("rst_cycles_zero", bus_data_r, 32'h0);
    bus_rd(A_ST, v);
    check_eq("rst_status", v, 32'h0);

    // RAM survives reset, so load it through the bus and reset again
    bus_wr(30'd0, 32'h0000_0013, 4'hF, old);
    bus_wr(30'd1, 32'hDEAD_BEEF, 4'hF, old);
    bus_wr(30'd5, 32'h1122_3344, 4'hF, old);
    @(negedge clock);
    reset    = 1'b0;
    bus_addr = 30'd0;
    repeat (2) @(negedge clock);
    @(negedge clock);
    reset    = 1'b1;
    bus_addr = 30'd1;
    check_eq("boot_word0", bus_data_r, 32'h0000_0013);
    @(negedge clock);
    check_eq("boot_word1", bus_data_r, 32'hDEAD_BEEF);

    bus_wr(30'd5, 32'h0000_00AB, 4'b0001, old);
    check_eq("bytewr_read_first", old, 32'h1122_3344);
    bus_rd(30'd5, v);
    check_eq("bytewr_lane0", v, 32'h1122_33AB);
    bus_wr(30'd5, 32'h5566_0000, 4'b1100, old);
    check_eq("bytewr_old2", old, 32'h1122_33AB);
    bus_rd(30'd5, v);
    check_eq("bytewr_lane32", v, 32'h5566_33AB);
    bus_rd(30'h0000_0105, v);
    check_eq("ram_alias", v, 32'h5566_33AB);

    drive(A_CYC, 32'h0, 4'h0);
    @(negedge clock);
    c0 = bus_data_r;
    repeat (10) @(negedge clock);
    c1 = bus_data_r;
    check_eq("cycles_delta", c1 - c0, 32'd10);
    bus_wr(A_GPIO, 32'hFFFF_FFFF, 4'b0010, old);
    check_eq("gpio_out_lane1", gpio_out, 32'h0000_FF00);
    bus_rd(A_GPIO, v);
    check_eq("gpio_read", v, 32'h0000_FF00);

    frame = {1'b1, 8'hA5, 1'b0};
    bus_wr(A_TX, 32'h0000_00A5, 4'b0001, old);
    bus_addr = A_ST;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clock);
      if (k <= 40) begin
        check_eq($sformatf("frame_bit_k%0d", k), {31'd0, uart_tx}, {31'd0, frame[(k-1)/4]});
      end
      if (k == 20) check_eq("frame_busy", bus_data_r, 32'h2);
      if (k == 46) begin
        check_eq("frame_idle_status", bus_data_r, 32'h0);
        check_eq("frame_idle_line", {31'd0, uart_tx}, 32'h1);
      end
    end

    mon_clr = 1'b1;
    @(negedge clock);
    mon_clr = 1'b0;
    mon_en  = 1'b1;
    bus_wr(A_TX, 32'h0000_00FF, 4'b0001, old);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 17; i++) drive(A_TX, 32'h0000_00FF, 4'b0001);
    @(negedge clock);
    bus_mask_w = 4'h0;
    bus_rd(A_ST, v);
    check_eq("ovf_status", v, 32'h7);
    bus_wr(A_ST, 32'h0, 4'hF, old);
    bus_rd(A_ST, v);
    check_eq("ovf_cleared_full", v, 32'h3);
    repeat (17 * 40 + 100) @(negedge clock);
    mon_en = 1'b0;
    check_eq("ovf_frame_count", fall_cnt, 32'd17);
    check_eq("ovf_back_to_back", last_fall - first_fall, 32'd640);
    check_eq("ovf_line_idle", {31'd0, uart_tx}, 32'h1);
    bus_rd(A_ST, v);
    check_eq("ovf_drained_status", v, 32'h0);

    bus_wr(A_TX, 32'h0000_00A5, 4'b0001, old);
    bus_wr(A_TX, 32'h0000_005A, 4'b0001, old);
    repeat (16) @(negedge clock);
    check_eq("midframe_bit3_low", {31'd0, uart_tx}, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("midframe_line_high", {31'd0, uart_tx}, 32'h1);
    check_eq("midframe_gpio_out", gpio_out, 32'h0);
    reset    = 1'b1;
    bus_addr = A_CYC;
    @(negedge clock);
    check_eq("midframe_cycles_zero", bus_data_r, 32'h0);
    bus_rd(A_ST, v);
    check_eq("midframe_status", v, 32'h0);
    bus_rd(A_GPIO, v);
    check_eq("midframe_gpio_read", v, 32'h0);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!uart_tx) lows++;
    end
    check_eq("midframe_no_tx", lows, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
